// File: rtl/window_pkg.sv
// Shared constants and the pipeline stage record for the window_apply block.
package window_pkg;

    localparam int DATA_W  = 16;
    localparam int COEF_W  = 18;
    localparam int WIN_LEN = 256;
    localparam int IDX_W   = $clog2(WIN_LEN);
    localparam int ADDR_W  = 12;
    localparam int Q_SHIFT = 17;

    // One pipeline slot: valid flag, signed sample and its index within the frame.
    typedef struct packed {
        logic                     valid;
        logic signed [DATA_W-1:0] data;
        logic [IDX_W-1:0]         idx;
    } stage_t;

endpackage

// File: rtl/window_mult_sat.sv
// Signed sample times unsigned Q1.17 coefficient, scaled back by 2^17 and
// saturated to the sample width. Optional macro WIN_ROUND_EN selects
// round-half-up; without it the scaling is a plain floor (truncation).
module window_mult_sat #(
    parameter int DATA_W = window_pkg::DATA_W,
    parameter int COEF_W = window_pkg::COEF_W
) (
    input  logic [DATA_W-1:0] i_data,
    input  logic [COEF_W-1:0] i_coef,
    output logic [DATA_W-1:0] o_res
);
    import window_pkg::*;

    localparam int PW = DATA_W + COEF_W + 1;

    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] w_scaled;
    logic                 w_in_range;

    // Coefficient is zero-extended so it is never read as negative.
    assign w_prod = PW'($signed(i_data)) * PW'($signed({1'b0, i_coef}));

`ifdef WIN_ROUND_EN
    localparam logic signed [PW-1:0] HALF = PW'(1) <<< (Q_SHIFT - 1);
    assign w_scaled = (w_prod + HALF) >>> Q_SHIFT;
`else
    assign w_scaled = w_prod >>> Q_SHIFT;
`endif

    // In range when every bit above the sample's sign bit copies it.
    assign w_in_range = (&w_scaled[PW-1:DATA_W-1]) || !(|w_scaled[PW-1:DATA_W-1]);

    assign o_res = w_in_range ? w_scaled[DATA_W-1:0]
                              : {w_scaled[PW-1], {(DATA_W-1){~w_scaled[PW-1]}}};

endmodule

// File: rtl/window_apply.sv
// Framing and windowing stage in front of the FFT. Tags each sample with its
// frame index, addresses the external registered coefficient ROM, multiplies
// and emits a windowed stream with SOF/EOF markers. Three stages:
// S1 sample+index, S2 sample+index aligned with win_in, S3 output register.
// Optional macro WIN_ROUND_EN (in window_mult_sat) selects rounding.
module window_apply #(
    parameter int DATA_W  = window_pkg::DATA_W,
    parameter int WIN_LEN = window_pkg::WIN_LEN,
    parameter int COEF_W  = window_pkg::COEF_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              frame_restart,
    output logic [11:0]       win_addr,
    input  logic [COEF_W-1:0] win_in,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_sof,
    output logic              m_eof
);
    import window_pkg::*;

    stage_t            r_s1;
    stage_t            r_s2;
    stage_t            r_s3;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_s_idx;
    logic [DATA_W-1:0] w_res;
    logic              w_en;
    logic              w_accept;

    // Whole pipeline moves together whenever the output slot is free or drained.
    assign w_en     = !r_s3.valid || m_ready;
    assign s_ready  = w_en;
    assign w_accept = s_valid && w_en;
    assign w_s_idx  = frame_restart ? '0 : r_idx;

    // While stalled the ROM re-reads S2's coefficient, so win_in stays matched
    // to S2 for any stall length; when advancing it fetches for S1 (next S2).
    assign win_addr = ADDR_W'(w_en ? r_s1.idx : r_s2.idx);

    // Frame index: restart forces 0, wraps at WIN_LEN with no gap cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_idx <= '0;
        else if (w_accept)
            r_idx <= w_s_idx + 1'b1;
        else if (frame_restart)
            r_idx <= '0;
    end

    window_mult_sat #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W)
    ) u_mult (
        .i_data (r_s2.data),
        .i_coef (win_in),
        .o_res  (w_res)
    );

    // Three-stage pipeline; bubbles advance with the valid flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else if (w_en) begin
            r_s1.valid <= s_valid;
            if (s_valid) begin
                r_s1.data <= s_data;
                r_s1.idx  <= w_s_idx;
            end
            r_s2       <= r_s1;
            r_s3.valid <= r_s2.valid;
            r_s3.data  <= w_res;
            r_s3.idx   <= r_s2.idx;
        end
    end

    assign m_valid = r_s3.valid;
    assign m_data  = r_s3.data;
    assign m_sof   = r_s3.valid && (r_s3.idx == '0);
    assign m_eof   = r_s3.valid && (r_s3.idx == IDX_W'(WIN_LEN - 1));

endmodule

// File: tb/tb_window_apply.sv
// Self-checking bench for window_apply: attaches a Hann ROM model, drives
// random streams and compares against a frame/arithmetic reference model.
module tb_window_apply;

    logic        clock;
    logic        reset_n;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        frame_restart;
    logic [11:0] win_addr;
    logic [17:0] win_in;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_sof;
    logic        m_eof;

    window_apply dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .frame_restart (frame_restart),
        .win_addr      (win_addr),
        .win_in        (win_in),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_sof         (m_sof),
        .m_eof         (m_eof)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

`ifdef WIN_ROUND_EN
    localparam int RND_POS = 2;
    localparam int RND_NEG = -1;
`else
    localparam int RND_POS = 1;
    localparam int RND_NEG = -2;
`endif

    typedef struct {
        int data;
        bit sof;
        bit eof;
        int idx;
    } rec_t;

    rec_t        out_q[$];
    rec_t        exp_q[$];
    logic [17:0] rom [256];
    logic        rom_force;
    logic [17:0] rom_force_val;
    int          m_idx;
    int          n_tests;
    int          n_fail;

    // Registered coefficient ROM, one-clock read latency.
    always @(posedge clock)
        win_in <= rom_force ? rom_force_val : rom[win_addr[7:0]];

    // Reference: s*w/2^17, optional +0.5, floor, clamp to 16-bit signed.
    function automatic int model_val(input int s, input int c);
        longint p;
        longint q;
        p = longint'(s) * longint'(c);
`ifdef WIN_ROUND_EN
        p = p + 64'sd65536;
`endif
        if (p >= 0) q = p / 131072;
        else        q = -((-p + 131071) / 131072);
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        return int'(q);
    endfunction

    // One cycle: drive at negedge, log transfers and model the accepted sample.
    task automatic tick(input logic v, input logic [15:0] d, input logic fr, input logic mr);
        rec_t r;
        s_valid = v; s_data = d; frame_restart = fr; m_ready = mr;
        #1;
        if (m_valid && m_ready) begin
            r.data = int'($signed(m_data)); r.sof = m_sof; r.eof = m_eof; r.idx = 0;
            out_q.push_back(r);
        end
        if (fr) m_idx = 0;
        if (v && s_ready) begin
            r.idx  = m_idx;
            r.data = model_val(int'($signed(d)), rom_force ? int'(rom_force_val) : int'(rom[m_idx]));
            r.sof  = (m_idx == 0);
            r.eof  = (m_idx == 255);
            exp_q.push_back(r);
            m_idx = (m_idx + 1) % 256;
        end
        @(negedge clock);
    endtask

    task automatic drain();
        for (int i = 0; i < 6; i++) tick(1'b0, 16'h0, 1'b0, 1'b1);
    endtask

    task automatic clear_q();
        out_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got %0b want 0", m_valid); end
        n_tests++; if (m_data !== 16'h0) begin n_fail++; $display("FAIL reset_m_data got %0h want 0", m_data); end
        n_tests++; if (m_sof !== 1'b0) begin n_fail++; $display("FAIL reset_m_sof got %0b want 0", m_sof); end
        n_tests++; if (m_eof !== 1'b0) begin n_fail++; $display("FAIL reset_m_eof got %0b want 0", m_eof); end
        n_tests++; if (win_addr !== 12'h0) begin n_fail++; $display("FAIL reset_win_addr got %0h want 0", win_addr); end
        n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready got %0b want 1", s_ready); end
        reset_n = 1'b1;
        m_idx = 0;
        @(negedge clock);
    endtask

    task automatic test_latency();
        clear_q();
        tick(1'b1, 16'd1234, 1'b0, 1'b1);
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL latency_c1 got m_valid=%0b want 0", m_valid); end
        tick(1'b0, 16'h0, 1'b0, 1'b1);
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL latency_c2 got m_valid=%0b want 0", m_valid); end
        tick(1'b0, 16'h0, 1'b0, 1'b1);
        n_tests++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL latency_c3 got m_valid=%0b want 1", m_valid); end
        drain();
        n_tests++;
        if (out_q.size() != 1 || exp_q.size() != 1) begin
            n_fail++; $display("FAIL latency_count got %0d want %0d", out_q.size(), exp_q.size());
        end else if (out_q[0].data != exp_q[0].data || out_q[0].sof != exp_q[0].sof) begin
            n_fail++; $display("FAIL latency_data got d=%0d sof=%0b want d=%0d sof=%0b",
                               out_q[0].data, out_q[0].sof, exp_q[0].data, exp_q[0].sof);
        end
    endtask

    task automatic test_frame_stream();
        clear_q();
        for (int i = 0; i < 256; i++) tick(1'b1, 16'd1000, (i == 0), 1'b1);
        drain();
        n_tests++; if (out_q.size() != 256) begin n_fail++; $display("FAIL frame_count got %0d want 256", out_q.size()); end
        if (out_q.size() == 256) begin
            n_tests++; if (out_q[0].data != 0) begin n_fail++; $display("FAIL frame_idx0 got %0d want 0", out_q[0].data); end
            n_tests++; if (out_q[64].data != 500) begin n_fail++; $display("FAIL frame_idx64 got %0d want 500", out_q[64].data); end
            n_tests++; if (out_q[128].data != 1000) begin n_fail++; $display("FAIL frame_idx128 got %0d want 1000", out_q[128].data); end
            n_tests++; if (out_q[0].sof != 1'b1) begin n_fail++; $display("FAIL frame_sof got %0b want 1", out_q[0].sof); end
            n_tests++; if (out_q[255].eof != 1'b1) begin n_fail++; $display("FAIL frame_eof got %0b want 1", out_q[255].eof); end
        end
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (out_q[i].data != exp_q[i].data || out_q[i].sof != exp_q[i].sof || out_q[i].eof != exp_q[i].eof) begin
                n_fail++; $display("FAIL frame[%0d] got d=%0d s=%0b e=%0b want d=%0d s=%0b e=%0b", i,
                                   out_q[i].data, out_q[i].sof, out_q[i].eof, exp_q[i].data, exp_q[i].sof, exp_q[i].eof);
            end
        end
    endtask

    task automatic test_fullscale_round();
        logic [15:0] d;
        clear_q();
        for (int i = 0; i < 512; i++) begin
            case (i)
                64:      d = 16'd3;
                128:     d = 16'h7FFF;
                320:     d = 16'hFFFD;
                384:     d = 16'h8000;
                default: d = 16'($urandom);
            endcase
            tick(1'b1, d, (i == 0), 1'b1);
        end
        drain();
        n_tests++; if (out_q.size() != 512) begin n_fail++; $display("FAIL full_count got %0d want 512", out_q.size()); end
        if (out_q.size() == 512) begin
            n_tests++; if (out_q[128].data != 32767) begin n_fail++; $display("FAIL full_pos got %0d want 32767", out_q[128].data); end
            n_tests++; if (out_q[384].data != -32768) begin n_fail++; $display("FAIL full_neg got %0d want -32768", out_q[384].data); end
            n_tests++; if (out_q[64].data != RND_POS) begin n_fail++; $display("FAIL round_pos got %0d want %0d", out_q[64].data, RND_POS); end
            n_tests++; if (out_q[320].data != RND_NEG) begin n_fail++; $display("FAIL round_neg got %0d want %0d", out_q[320].data, RND_NEG); end
        end
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (out_q[i].data != exp_q[i].data || out_q[i].sof != exp_q[i].sof || out_q[i].eof != exp_q[i].eof) begin
                n_fail++; $display("FAIL full[%0d] got d=%0d s=%0b e=%0b want d=%0d s=%0b e=%0b", i,
                                   out_q[i].data, out_q[i].sof, out_q[i].eof, exp_q[i].data, exp_q[i].sof, exp_q[i].eof);
            end
        end
    endtask

    task automatic test_saturation();
        logic [15:0] d;
        clear_q();
        rom_force = 1'b1; rom_force_val = 18'h3FFFF;
        for (int i = 0; i < 40; i++) begin
            case (i)
                0:       d = 16'h7FFF;
                1:       d = 16'h8000;
                2:       d = 16'd100;
                3:       d = 16'hFF9C;
                default: d = 16'($urandom);
            endcase
            tick(1'b1, d, 1'b0, 1'b1);
        end
        drain();
        rom_force = 1'b0;
        n_tests++; if (out_q.size() != 40) begin n_fail++; $display("FAIL sat_count got %0d want 40", out_q.size()); end
        if (out_q.size() == 40) begin
            n_tests++; if (out_q[0].data != 32767) begin n_fail++; $display("FAIL sat_pos got %0d want 32767", out_q[0].data); end
            n_tests++; if (out_q[1].data != -32768) begin n_fail++; $display("FAIL sat_neg got %0d want -32768", out_q[1].data); end
        end
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (out_q[i].data != exp_q[i].data) begin
                n_fail++; $display("FAIL sat[%0d] got %0d want %0d", i, out_q[i].data, exp_q[i].data);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        clear_q();
        for (int i = 0; i < 40; i++) tick(1'b1, 16'($urandom), (i == 0), 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick(1'b1, 16'($urandom), 1'b0, 1'b0);
            n = out_q.size();
            n_tests++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL bp_s_ready[%0d] got %0b want 0", k, s_ready); end
            n_tests++;
            if (m_valid !== 1'b1 || int'($signed(m_data)) != exp_q[n].data) begin
                n_fail++; $display("FAIL bp_hold[%0d] got v=%0b d=%0d want v=1 d=%0d", k, m_valid, $signed(m_data), exp_q[n].data);
            end
            n_tests++;
            if (win_addr !== 12'(exp_q[n + 1].idx)) begin
                n_fail++; $display("FAIL bp_win_addr[%0d] got %0d want %0d", k, win_addr, exp_q[n + 1].idx);
            end
        end
        for (int i = 0; i < 40; i++) tick(1'b1, 16'($urandom), 1'b0, 1'b1);
        for (int i = 0; i < 600; i++)
            tick(($urandom % 10) < 7, 16'($urandom), ($urandom % 64) == 0, ($urandom % 10) < 7);
        drain();
        n_tests++;
        if (out_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL bp_count got %0d want %0d", out_q.size(), exp_q.size());
        end
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (out_q[i].data != exp_q[i].data || out_q[i].sof != exp_q[i].sof || out_q[i].eof != exp_q[i].eof) begin
                n_fail++; $display("FAIL bp[%0d] got d=%0d s=%0b e=%0b want d=%0d s=%0b e=%0b", i,
                                   out_q[i].data, out_q[i].sof, out_q[i].eof, exp_q[i].data, exp_q[i].sof, exp_q[i].eof);
            end
        end
    endtask

    task automatic test_restart();
        clear_q();
        for (int i = 0; i < 356; i++) tick(1'b1, 16'($urandom), (i == 0) || (i == 100), 1'b1);
        drain();
        n_tests++; if (out_q.size() != 356) begin n_fail++; $display("FAIL rst_count got %0d want 356", out_q.size()); end
        if (out_q.size() == 356) begin
            n_tests++; if (out_q[99].sof != 1'b0) begin n_fail++; $display("FAIL rst_pre_sof got %0b want 0", out_q[99].sof); end
            n_tests++; if (out_q[100].sof != 1'b1) begin n_fail++; $display("FAIL rst_sof got %0b want 1", out_q[100].sof); end
            n_tests++; if (out_q[355].eof != 1'b1) begin n_fail++; $display("FAIL rst_eof got %0b want 1", out_q[355].eof); end
        end
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (out_q[i].data != exp_q[i].data || out_q[i].sof != exp_q[i].sof || out_q[i].eof != exp_q[i].eof) begin
                n_fail++; $display("FAIL rst[%0d] got d=%0d s=%0b e=%0b want d=%0d s=%0b e=%0b", i,
                                   out_q[i].data, out_q[i].sof, out_q[i].eof, exp_q[i].data, exp_q[i].sof, exp_q[i].eof);
            end
        end
    endtask

    task automatic test_reset_midframe();
        clear_q();
        for (int i = 0; i < 3; i++) tick(1'b1, 16'($urandom), 1'b0, 1'b1);
        n_tests++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL mid_inflight got %0b want 1", m_valid); end
        s_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL mid_drop got %0b want 0", m_valid); end
        n_tests++; if (m_data !== 16'h0) begin n_fail++; $display("FAIL mid_data got %0h want 0", m_data); end
        @(negedge clock);
        reset_n = 1'b1;
        clear_q();
        m_idx = 0;
        for (int i = 0; i < 10; i++) tick(1'b1, 16'($urandom), 1'b0, 1'b1);
        drain();
        n_tests++; if (out_q.size() != 10) begin n_fail++; $display("FAIL mid_count got %0d want 10", out_q.size()); end
        if (out_q.size() > 0) begin
            n_tests++; if (out_q[0].sof != 1'b1) begin n_fail++; $display("FAIL mid_sof got %0b want 1", out_q[0].sof); end
        end
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (out_q[i].data != exp_q[i].data || out_q[i].sof != exp_q[i].sof) begin
                n_fail++; $display("FAIL mid[%0d] got d=%0d s=%0b want d=%0d s=%0b", i,
                                   out_q[i].data, out_q[i].sof, exp_q[i].data, exp_q[i].sof);
            end
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0; m_idx = 0;
        rom_force = 1'b0; rom_force_val = '0;
        s_valid = 1'b0; s_data = '0; frame_restart = 1'b0; m_ready = 1'b1;
        reset_n = 1'b0;
        for (int i = 0; i < 256; i++)
            rom[i] = 18'($rtoi(65536.0 * (1.0 - $cos(2.0 * 3.14159265358979 * real'(i) / 256.0)) + 0.5));
        @(negedge clock);
        test_reset();
        test_latency();
        test_frame_stream();
        test_fullscale_round();
        test_saturation();
        test_backpressure();
        test_restart();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
